// File: rtl/fetch_pkg.sv
// Shared types for the fetch path: default widths, sequencer state encoding
// and the prefetch queue entry layout.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} words; flush beats push.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0]            wr_ptr_reg;
  logic [PTR_W-1:0]            rd_ptr_reg;
  logic [CNT_W-1:0]            count_reg;
  logic [DEPTH-1:0][WIDTH-1:0] entry_data;

  logic do_push;
  logic do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= '0;
      end else if (do_push && wr_ptr_reg == PTR_W'(gi)) begin
        data_reg <= push_data;
      end
    end

    assign entry_data[gi] = data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = entry_data[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, feeds a prefetch queue, handles
// redirect/halt. Optional macro FETCH_BOUNDS_CHECK_EN adds the sticky fault.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                MEM_DEPTH = 32,
  parameter int                Q_DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instruction,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
`ifdef FETCH_BOUNDS_CHECK_EN
  output logic              fault,
`endif
  output logic              halted
);

  localparam int CNT_W = $clog2(Q_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  logic              push;
  logic              flush;
  logic              pop;
  logic              can_push;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  head_data;

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({pc_reg, instruction}),
    .head_data (head_data),
    .count     (q_count)
  );

  assign out_valid = (q_count != '0);
  assign pop       = out_valid & out_ready;
  assign can_push  = (state_reg == RUN) && ((q_count < CNT_W'(Q_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Redirect dominates everything, including a pending halt or fault.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush      = 1'b1;
      pc_next    = redirect_pc;
      state_next = RUN;
    end else if (state_reg == RUN) begin
      if (halt_req) begin
        state_next = HALTED;
`ifdef FETCH_BOUNDS_CHECK_EN
      end else if (pc_reg >= ADDR_W'(MEM_DEPTH)) begin
        state_next = FAULT;
`endif
      end else if (can_push) begin
        push    = 1'b1;
        pc_next = pc_reg + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    instr_addr = pc_reg;
    halted     = (state_reg == HALTED);
`ifdef FETCH_BOUNDS_CHECK_EN
    fault      = (state_reg == FAULT);
`endif
  end

  assign out_pc    = head_data[ENT_W-1 -: ADDR_W];
  assign out_instr = head_data[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed phases push expected deliveries,
// a negedge monitor pops and compares. Covers FETCH_BOUNDS_CHECK_EN when defined.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  fetch_entry_t exp_q[$];

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .instr_addr     (instr_addr),
    .instruction    (instruction),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
`ifdef FETCH_BOUNDS_CHECK_EN
    .fault          (fault),
`endif
    .halted         (halted)
  );

  // Memory image: in range words are C0DE_xxxx, anything beyond is BAD0_xxxx.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32) return 32'hC0DE_0000 + a;
    return 32'hBAD0_0000 + {16'h0, a[15:0]};
  endfunction

  assign instruction = mem_word(instr_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      $display("deliver pc=%08h instr=%08h", out_pc, out_instr);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got pc %0h expected none", out_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("deliver_pc", {32'h0, out_pc}, {32'h0, e.pc});
        chk("deliver_instr", {32'h0, out_instr}, {32'h0, e.instr});
      end
    end
  end

  initial begin
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt_req = 1'b0;
    tick(); tick();
    chk("reset_valid", {63'h0, out_valid}, 64'h0);
    chk("reset_addr", {32'h0, instr_addr}, 64'h0);
    chk("reset_halted", {63'h0, halted}, 64'h0);
    chk("reset_out_pc", {32'h0, out_pc}, 64'h0);
    chk("reset_out_instr", {32'h0, out_instr}, 64'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("reset_fault", {63'h0, fault}, 64'h0);
`endif

    // Streaming: PCs 0..5 one per cycle
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_pc(i);
    tick();
    chk("first_valid", {63'h0, out_valid}, 64'h1);
    chk("first_pc", {32'h0, out_pc}, 64'h0);
    chk("first_instr", {32'h0, out_instr}, 64'hC0DE_0000);
    repeat (6) tick();

    // Reset mid-run
    out_ready = 1'b0; rst = 1'b1;
    tick();
    chk("midrst_valid", {63'h0, out_valid}, 64'h0);
    chk("midrst_addr", {32'h0, instr_addr}, 64'h0);
    rst = 1'b0;

    // Backpressure: queue fills at 2, pc holds at 2
    repeat (4) tick();
    chk("bp_addr", {32'h0, instr_addr}, 64'h2);
    chk("bp_valid", {63'h0, out_valid}, 64'h1);
    chk("bp_head", {32'h0, out_pc}, 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_pc(i);
    repeat (3) tick();

    // Redirect with PCs 3,4 queued
    out_ready = 1'b0;
    chk("pre_redir_head", {32'h0, out_pc}, 64'h3);
    redirect_valid = 1'b1; redirect_pc = 32'd1;
    tick();
    chk("redir_flush", {63'h0, out_valid}, 64'h0);
    chk("redir_addr", {32'h0, instr_addr}, 64'h1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    expect_pc(1); expect_pc(2);
    repeat (3) tick();

    // Halt at pc 4 with PC 3 queued
    out_ready = 1'b0;
    chk("pre_halt_addr", {32'h0, instr_addr}, 64'h4);
    halt_req = 1'b1;
    tick();
    chk("halt_halted", {63'h0, halted}, 64'h1);
    chk("halt_addr", {32'h0, instr_addr}, 64'h4);
    chk("halt_head", {32'h0, out_pc}, 64'h3);
    halt_req = 1'b0; out_ready = 1'b1;
    expect_pc(3);
    repeat (2) tick();
    chk("halt_drained", {63'h0, out_valid}, 64'h0);
    chk("halt_no_fetch", {32'h0, instr_addr}, 64'h4);
    chk("halt_sticky", {63'h0, halted}, 64'h1);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    expect_pc(0); expect_pc(1);
    tick();
    chk("resume_halted", {63'h0, halted}, 64'h0);
    chk("resume_addr", {32'h0, instr_addr}, 64'h0);
    redirect_valid = 1'b0;
    repeat (3) tick();

    // Halt and redirect together: redirect wins, halt applies next cycle
    out_ready = 1'b0; halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd2;
    tick();
    chk("hr_halted", {63'h0, halted}, 64'h0);
    chk("hr_addr", {32'h0, instr_addr}, 64'h2);
    chk("hr_flush", {63'h0, out_valid}, 64'h0);
    redirect_valid = 1'b0;
    tick();
    chk("hr_then_halt", {63'h0, halted}, 64'h1);
    chk("hr_then_addr", {32'h0, instr_addr}, 64'h2);
    halt_req = 1'b0;

`ifndef FETCH_BOUNDS_CHECK_EN
    // PC wraps from all-ones to zero
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    expect_pc(32'hFFFF_FFFF); expect_pc(0);
    repeat (3) tick();
    out_ready = 1'b0;
    chk("wrap_addr", {32'h0, instr_addr}, 64'h2);
    chk("wrap_head", {32'h0, out_pc}, 64'h1);
`endif

    // Run off the end of memory from PC 31
    redirect_valid = 1'b1; redirect_pc = 32'd31;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    expect_pc(31);
`ifdef FETCH_BOUNDS_CHECK_EN
    tick(); tick();
    chk("fault_set", {63'h0, fault}, 64'h1);
    chk("fault_addr", {32'h0, instr_addr}, 64'h20);
    chk("fault_drained", {63'h0, out_valid}, 64'h0);
    chk("fault_not_halted", {63'h0, halted}, 64'h0);
    tick();
    chk("fault_sticky", {63'h0, fault}, 64'h1);
    chk("fault_hold", {32'h0, instr_addr}, 64'h20);
`else
    expect_pc(32);
    repeat (3) tick();
    chk("oob_addr", {32'h0, instr_addr}, 64'h22);
`endif
    out_ready = 1'b0;

    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    chk("recover_addr", {32'h0, instr_addr}, 64'h0);
    chk("recover_flush", {63'h0, out_valid}, 64'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("recover_fault", {63'h0, fault}, 64'h0);
`endif
    redirect_valid = 1'b0; out_ready = 1'b1;
    expect_pc(0); expect_pc(1);
    repeat (3) tick();

    // Final reset mid-run clears everything in one edge
    out_ready = 1'b0; rst = 1'b1;
    tick();
    chk("final_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("final_rst_addr", {32'h0, instr_addr}, 64'h0);
    chk("final_rst_out_pc", {32'h0, out_pc}, 64'h0);
    chk("final_rst_out_instr", {32'h0, out_instr}, 64'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("final_rst_fault", {63'h0, fault}, 64'h0);
`endif
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_fill", {32'h0, instr_addr}, 64'h2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
